// File: rtl/divider_sequencer.sv
// -----------------------------------------------------------------------------
// divider_sequencer
//
// Multi-cycle signed/unsigned integer divide sequencer for the HI/LO path.
// A radix-2 restoring divider runs on operand magnitudes for WIDTH cycles. The
// quotient (LO) and remainder (HI) are then sign-corrected and presented with a
// one-cycle valid strobe. The execute stage is held with a combinational stall
// while a divide is being accepted or is iterating.
//
// Optional feature (compile-time macro):
//   DIVIDER_ZERO_FAST_EN - an accepted start with divisor == 0 skips the
//                          iterations and goes straight to DONE. The results
//                          are identical to the full-iteration results.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   start      in   divide request (level, sampled in IDLE only)
//   signed_div in   1 = DIV (two's complement), 0 = DIVU
//   dividend   in   WIDTH-bit rs operand
//   divisor    in   WIDTH-bit rt operand
//   cancel     in   flush/exception kill, aborts any operation
//   stall      out  hold execute stage (combinational)
//   busy       out  state != IDLE
//   valid      out  one-cycle result strobe (HI/LO write enable)
//   quotient   out  WIDTH-bit result to LO
//   remainder  out  WIDTH-bit result to HI
// -----------------------------------------------------------------------------
module divider_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             stall,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rem;      // partial remainder
    logic [WIDTH-1:0] r_quo;      // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] r_dvsr;     // divisor magnitude
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_q_hold;
    logic [WIDTH-1:0] r_r_hold;

    // Two's complement negate in WIDTH bits; the most negative value maps to itself.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic           is_neg);
        return is_neg ? negate(v) : v;
    endfunction

    logic signed [WIDTH-1:0] w_dividend_s;
    logic signed [WIDTH-1:0] w_divisor_s;
    logic                    w_dvd_neg;
    logic                    w_dvs_neg;
    logic                    w_accept;
    logic                    w_zero;
    logic                    w_last;
    logic [WIDTH:0]          w_shift;
    logic                    w_ge;
    logic [WIDTH-1:0]        w_sub;
    logic [WIDTH-1:0]        w_rem_next;
    logic [WIDTH-1:0]        w_quo_next;
    logic [WIDTH-1:0]        w_q_fix;
    logic [WIDTH-1:0]        w_r_fix;

    assign w_dividend_s = dividend;
    assign w_divisor_s  = divisor;
    assign w_dvd_neg    = signed_div & (w_dividend_s < 0);
    assign w_dvs_neg    = signed_div & (w_divisor_s < 0);
    assign w_accept     = (r_state == IDLE) & start & ~cancel;
    assign w_zero       = (divisor == '0);
    assign w_last       = (r_count == CW'(WIDTH - 1));

    // Restoring step: shift {rem,quo} left by one and trial-subtract the divisor.
    // The shifted value is below 2*divisor, so the kept result always fits WIDTH bits.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvsr});
    assign w_sub      = w_shift[WIDTH-1:0] - r_dvsr;
    assign w_rem_next = w_ge ? w_sub : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

    assign w_q_fix = r_neg_q ? negate(r_quo) : r_quo;
    assign w_r_fix = r_neg_r ? negate(r_rem) : r_rem;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef DIVIDER_ZERO_FAST_EN
                    w_next = w_zero ? DONE : RUN;
`else
                    w_next = RUN;
`endif
                end
            end
            RUN: begin
                if (cancel)      w_next = IDLE;
                else if (w_last) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_q_hold <= '0;
            r_r_hold <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r <= w_dvd_neg;
                        r_dvsr  <= magnitude(divisor, w_dvs_neg);
                        r_count <= '0;
`ifdef DIVIDER_ZERO_FAST_EN
                        // Preload what WIDTH iterations against a zero divisor would leave.
                        if (w_zero) begin
                            r_rem <= magnitude(dividend, w_dvd_neg);
                            r_quo <= '1;
                        end else begin
                            r_rem <= '0;
                            r_quo <= magnitude(dividend, w_dvd_neg);
                        end
`else
                        r_rem <= '0;
                        r_quo <= magnitude(dividend, w_dvd_neg);
`endif
                    end
                end
                RUN: begin
                    if (!cancel) begin
                        r_rem   <= w_rem_next;
                        r_quo   <= w_quo_next;
                        r_count <= r_count + CW'(1);
                    end
                end
                DONE: begin
                    // A cancelled DONE discards its results; the held values stay.
                    if (!cancel) begin
                        r_q_hold <= w_q_fix;
                        r_r_hold <= w_r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign valid     = (r_state == DONE) & ~cancel;
    assign stall     = rst & (w_accept | (r_state == RUN));
    assign quotient  = (r_state == DONE) ? w_q_fix : r_q_hold;
    assign remainder = (r_state == DONE) ? w_r_fix : r_r_hold;

endmodule

// File: tb/tb_divider_sequencer.sv
module tb_divider_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        stall;
    logic        busy;
    logic        valid;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_chk  = 0;
    int n_fail = 0;
    int n_valid = 0;
    logic [63:0] sb_q[$];   // {quotient, remainder}

    divider_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .cancel     (cancel),
        .stall      (stall),
        .busy       (busy),
        .valid      (valid),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every valid pulse pops one expected result.
    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                chk("quotient", {32'd0, quotient}, {32'd0, e[63:32]});
                chk("remainder", {32'd0, remainder}, {32'd0, e[31:0]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one divide and time it; stall must cover exactly the cycles before valid.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] q, input logic [31:0] r,
                           input int lat);
        int n;
        int sc;
        start = 1'b1; signed_div = sgn; dividend = a; divisor = b;
        sb_q.push_back({q, r});
        #1;
        sc = int'(stall);
        tick();
        start = 1'b0;
        n = 1;
        while (!valid && n < 100) begin
            sc += int'(stall);
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(lat));
        chk({tag, "_stall_cycles"}, 64'(sc), 64'(lat));
        chk({tag, "_stall_in_done"}, {63'd0, stall}, 64'd0);
        tick();
        chk({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
    endtask

    int zero_lat;

    initial begin
`ifdef DIVIDER_ZERO_FAST_EN
        zero_lat = 1;
`else
        zero_lat = 33;
`endif
        rst = 1'b0; start = 1'b0; signed_div = 1'b0;
        dividend = '0; divisor = '0; cancel = 1'b0;
        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_valid", {63'd0, valid}, 64'd0);
        chk("reset_stall", {63'd0, stall}, 64'd0);
        chk("reset_q", {32'd0, quotient}, 64'd0);
        chk("reset_r", {32'd0, remainder}, 64'd0);
        tick(); tick();
        rst = 1'b1;
        tick();

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run_div("div_minneg", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
        run_div("divu_big", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 33);

        // Cancel in RUN cycle 10: no result, back to IDLE at the next edge.
        start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        cancel = 1'b1;
        #1;
        chk("cancel_valid", {63'd0, valid}, 64'd0);
        tick();
        cancel = 1'b0;
        #1;
        chk("cancel_busy", {63'd0, busy}, 64'd0);
        chk("cancel_stall", {63'd0, stall}, 64'd0);
        tick();
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, zero_lat);
        run_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB, zero_lat);

        // Reset mid-operation at RUN cycle 20.
        start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
        tick();
        for (int i = 1; i < 20; i++) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_valid", {63'd0, valid}, 64'd0);
        chk("midrst_stall", {63'd0, stall}, 64'd0);
        chk("midrst_q", {32'd0, quotient}, 64'd0);
        chk("midrst_r", {32'd0, remainder}, 64'd0);
        tick();
        chk("inrst_stall", {63'd0, stall}, 64'd0);
        start = 1'b0;
        rst = 1'b1;
        tick();

        // start with cancel held in IDLE is never accepted.
        start = 1'b1; cancel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("startcancel_stall", {63'd0, stall}, 64'd0);
            tick();
            chk("startcancel_busy", {63'd0, busy}, 64'd0);
        end
        start = 1'b0; cancel = 1'b0;
        tick();

        // Back-to-back with start held.
        begin
            int n;
            start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
            sb_q.push_back({32'd14, 32'd2});
            sb_q.push_back({32'd8, 32'd0});
            tick();
            dividend = 32'd64; divisor = 32'd8;
            n = 1;
            while (!valid && n < 100) begin tick(); n++; end
            chk("b2b_first_latency", 64'(n), 64'd33);
            tick();
            chk("b2b_idle_busy", {63'd0, busy}, 64'd0);
            chk("b2b_accept_stall", {63'd0, stall}, 64'd1);
            tick();
            start = 1'b0;
            n = 1;
            while (!valid && n < 100) begin tick(); n++; end
            chk("b2b_second_latency", 64'(n), 64'd33);
            tick();
        end

        tick(); tick();
        chk("sb_left", 64'(sb_q.size()), 64'd0);
        chk("valid_pulses", 64'(n_valid), 64'd10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test expected finish");
        $fatal(1, "timeout");
    end

endmodule
